// File: rtl/led_frame_buffer_if.sv
// Bundle of the pixel-store write port, frame control and the GRB pixel stream
// of led_frame_buffer; master drives writes/control/ready, slave is the buffer.
interface led_frame_buffer_if;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        frame_start;
  logic [2:0]  num_leds;
  logic [2:0]  bright;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;
  logic        busy;
  logic        frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, frame_start, num_leds, bright, pix_ready,
    input  pix_data, pix_valid, pix_last, busy, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, frame_start, num_leds, bright, pix_ready,
    output pix_data, pix_valid, pix_last, busy, frame_done
  );
endinterface

// File: rtl/led_frame_buffer.sv
// 8 x 24-bit GRB frame buffer streaming one frame per frame_start over a valid/ready port.
// Optional per-channel dimming shifter is enabled by defining LFB_DIMMING_EN.
module led_frame_buffer (
  input  logic              clk,
  input  logic              reset,
  led_frame_buffer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [23:0] r_store [8];
  logic [2:0]  r_idx, w_idx_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  w_idx_inc, w_load_idx;
  logic [23:0] r_pix_data, w_pix_data_nxt, w_load_word;
  logic        r_pix_valid, w_pix_valid_nxt;
  logic        r_pix_last, w_pix_last_nxt;

  assign w_idx_inc  = r_idx + 3'd1;
  assign w_load_idx = (r_state == IDLE) ? 3'd0 : w_idx_inc;

`ifdef LFB_DIMMING_EN
  logic [2:0] r_bright;
  logic [2:0] w_bright;

  // The first word is loaded on the frame_start edge, so it must see the live input.
  assign w_bright    = (r_state == IDLE) ? bus.bright : r_bright;
  assign w_load_word = {r_store[w_load_idx][23:16] >> w_bright,
                        r_store[w_load_idx][15:8]  >> w_bright,
                        r_store[w_load_idx][7:0]   >> w_bright};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bright <= '0;
    end else if (r_state == IDLE && bus.frame_start) begin
      r_bright <= bus.bright;
    end
  end
`else
  logic w_unused_bright;
  assign w_unused_bright = ^bus.bright;
  assign w_load_word     = r_store[w_load_idx];
`endif

  // Store reads above use the pre-edge contents, so a colliding write lands next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_store[i] <= '0;
      end
    end else if (bus.wr_en) begin
      r_store[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pix_data  <= w_pix_data_nxt;
      r_pix_valid <= w_pix_valid_nxt;
      r_pix_last  <= w_pix_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_pix_data_nxt  = r_pix_data;
    w_pix_valid_nxt = r_pix_valid;
    w_pix_last_nxt  = r_pix_last;
    unique case (r_state)
      IDLE: begin
        if (bus.frame_start) begin
          w_state_nxt     = STREAM;
          w_cnt_nxt       = bus.num_leds;
          w_idx_nxt       = '0;
          w_pix_data_nxt  = w_load_word;
          w_pix_valid_nxt = 1'b1;
          w_pix_last_nxt  = (bus.num_leds == 3'd0);
        end
      end
      STREAM: begin
        if (r_pix_valid && bus.pix_ready) begin
          if (r_idx != r_cnt) begin
            w_idx_nxt      = w_idx_inc;
            w_pix_data_nxt = w_load_word;
            w_pix_last_nxt = (w_idx_inc == r_cnt);
          end else begin
            w_state_nxt     = DONE;
            w_pix_data_nxt  = '0;
            w_pix_valid_nxt = 1'b0;
            w_pix_last_nxt  = 1'b0;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.pix_data   = r_pix_data;
  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_last   = r_pix_last;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = (r_state == DONE);
endmodule

// File: tb/tb_led_frame_buffer.sv
// Self-checking bench for led_frame_buffer: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_led_frame_buffer;
  logic        clk = 1'b0;
  logic        reset;
  int unsigned total = 0;
  int unsigned bad   = 0;

  led_frame_buffer_if bus ();

  led_frame_buffer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] shade(input logic [23:0] w, input logic [2:0] s);
`ifdef LFB_DIMMING_EN
    logic [7:0] g, r, b;
    g = w[23:16] >> s;
    r = w[15:8] >> s;
    b = w[7:0] >> s;
    return {g, r, b};
`else
    logic unused_s;
    unused_s = ^s;
    return w;
`endif
  endfunction

  // Reference model: frame = words store[0..cnt], each word read from the store as it
  // stood just before it was offered; frame_done follows the final acceptance.
  logic [23:0] m_store [8];
  logic        m_active, m_done;
  logic [2:0]  m_pos, m_cnt, m_bright;
  logic [23:0] m_cur;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_store[i] <= '0;
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_pos    <= '0;
      m_cnt    <= '0;
      m_bright <= '0;
      m_cur    <= '0;
    end else begin
      if (m_done) begin
        m_done <= 1'b0;
      end else if (m_active) begin
        if (bus.pix_ready) begin
          if (m_pos == m_cnt) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
          end else begin
            m_pos <= m_pos + 3'd1;
            m_cur <= shade(m_store[m_pos + 3'd1], m_bright);
          end
        end
      end else if (bus.frame_start) begin
        m_active <= 1'b1;
        m_pos    <= '0;
        m_cnt    <= bus.num_leds;
        m_bright <= bus.bright;
        m_cur    <= shade(m_store[0], bus.bright);
      end
      if (bus.wr_en) m_store[bus.wr_addr] <= bus.wr_data;
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("valid", 32'(bus.pix_valid), 32'(m_active));
      chk("data", 32'(bus.pix_data), 32'(m_active ? m_cur : 24'd0));
      chk("last", 32'(bus.pix_last), 32'(m_active && (m_pos == m_cnt)));
      chk("busy", 32'(bus.busy), 32'(m_active || m_done));
      chk("frame_done", 32'(bus.frame_done), 32'(m_done));
    end
  end

  task automatic write_px(input logic [2:0] addr, input logic [23:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic start_frame(input logic [2:0] n);
    bus.num_leds    = n;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  logic [23:0] bp_exp [3];

  initial begin
    reset           = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.frame_start = 1'b0;
    bus.num_leds    = '0;
    bus.bright      = '0;
    bus.pix_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(bus.pix_data), 32'h0);
    chk("rst_valid", 32'(bus.pix_valid), 32'h0);
    chk("rst_last", 32'(bus.pix_last), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.frame_done), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Single LED
    write_px(3'd0, 24'h00FF00);
    bus.pix_ready = 1'b1;
    start_frame(3'd0);
    chk("single_data", 32'(bus.pix_data), 32'h00FF00);
    chk("single_valid", 32'(bus.pix_valid), 32'h1);
    chk("single_last", 32'(bus.pix_last), 32'h1);
    chk("single_busy1", 32'(bus.busy), 32'h1);
    @(negedge clk);
    chk("single_done", 32'(bus.frame_done), 32'h1);
    chk("single_valid0", 32'(bus.pix_valid), 32'h0);
    chk("single_zero", 32'(bus.pix_data), 32'h0);
    chk("single_busy2", 32'(bus.busy), 32'h1);
    @(negedge clk);
    chk("single_idle", 32'(bus.busy), 32'h0);
    chk("single_done0", 32'(bus.frame_done), 32'h0);

    // Full frame, back to back
    for (int i = 0; i < 8; i++) write_px(3'(i), 24'(i * 32'h010101));
    start_frame(3'd7);
    for (int k = 0; k < 8; k++) begin
      chk("full_data", 32'(bus.pix_data), k * 32'h010101);
      chk("full_last", 32'(bus.pix_last), 32'(k == 7));
      chk("full_valid", 32'(bus.pix_valid), 32'h1);
      @(negedge clk);
    end
    chk("full_done", 32'(bus.frame_done), 32'h1);
    @(negedge clk);

    // Backpressure
    write_px(3'd0, 24'hC0FFEE);
    bp_exp[0] = 24'hC0FFEE;
    bp_exp[1] = 24'h010101;
    bp_exp[2] = 24'h020202;
    bus.pix_ready = 1'b0;
    start_frame(3'd2);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", 32'(bus.pix_data), 32'hC0FFEE);
      @(negedge clk);
    end
    bus.pix_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_word", 32'(bus.pix_data), 32'(bp_exp[k]));
      @(negedge clk);
    end
    chk("bp_done", 32'(bus.frame_done), 32'h1);
    @(negedge clk);

    // Write to addr 1 on the edge that loads idx 1
    start_frame(3'd1);
    chk("col_w0", 32'(bus.pix_data), 32'hC0FFEE);
    write_px(3'd1, 24'hABCDEF);
    chk("col_old", 32'(bus.pix_data), 32'h010101);
    chk("col_last", 32'(bus.pix_last), 32'h1);
    repeat (2) @(negedge clk);
    start_frame(3'd1);
    @(negedge clk);
    chk("col_new", 32'(bus.pix_data), 32'hABCDEF);
    repeat (2) @(negedge clk);

    // Reset during second word of four
    start_frame(3'd3);
    @(negedge clk);
    chk("mid_word1", 32'(bus.pix_data), 32'hABCDEF);
    reset = 1'b0;
    #1;
    chk("mid_data", 32'(bus.pix_data), 32'h0);
    chk("mid_valid", 32'(bus.pix_valid), 32'h0);
    chk("mid_last", 32'(bus.pix_last), 32'h0);
    chk("mid_busy", 32'(bus.busy), 32'h0);
    chk("mid_done", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(bus.frame_done), 32'h0);
      chk("post_rst_busy", 32'(bus.busy), 32'h0);
    end
    write_px(3'd0, 24'h5A5A5A);
    start_frame(3'd0);
    chk("restart_data", 32'(bus.pix_data), 32'h5A5A5A);
    repeat (2) @(negedge clk);

    // Dimming
    write_px(3'd0, 24'h80FF40);
    bus.bright = 3'd2;
    start_frame(3'd0);
`ifdef LFB_DIMMING_EN
    chk("dim_data", 32'(bus.pix_data), 32'h203F10);
`else
    chk("dim_data", 32'(bus.pix_data), 32'h80FF40);
`endif
    bus.bright = 3'd0;
    repeat (2) @(negedge clk);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bus.wr_en       = ($urandom_range(0, 2) == 0);
      bus.wr_addr     = 3'($urandom_range(0, 7));
      bus.wr_data     = 24'($urandom);
      bus.frame_start = ($urandom_range(0, 3) == 0);
      bus.num_leds    = 3'($urandom_range(0, 7));
      bus.bright      = 3'($urandom_range(0, 7));
      bus.pix_ready   = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    bus.wr_en       = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_ready   = 1'b1;
    repeat (12) @(negedge clk);
    chk("drain_idle", 32'(bus.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
